fifo_8bit: RTL and testbench

//   Synchronous single-clock FIFO buffer, 8-bit data, 8 entries deep.

---
 rtl/fifo_8bit_pkg.sv | 9 +
 rtl/fifo_8bit_mem.sv | 36 +++
 rtl/fifo_8bit.sv | 57 +++++
 tb/tb_fifo_8bit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fifo_8bit_pkg.sv
// Shared constants and word type for the 8-bit FIFO slice.
package fifo_8bit_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;

  typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_8bit_mem.sv
// DEPTH x WIDTH register array: synchronous write port, registered read port.
module fifo_8bit_mem
  import fifo_8bit_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_8bit.sv
// Single-clock byte FIFO: pointer/flag logic and accept gating around the array.
module fifo_8bit
  import fifo_8bit_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  // One extra wrap bit on each pointer separates full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_ok;
  logic        rd_ok;

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    wr_ok = wr && !full;
    rd_ok = rd && !empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  fifo_8bit_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok && !rst),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_fifo_8bit.sv
// Directed self-checking bench for fifo_8bit.
module tb_fifo_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       wr;
  logic       rd;
  logic [7:0] data_out;
  logic       empty;
  logic       full;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fifo_8bit #(
    .WIDTH (8),
    .DEPTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    wr      = 1'b1;
    rd      = 1'b1;
    data_in = 8'h55;

    // Reset held two cycles with both requests active.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_dout", 32'(data_out), 32'h00);
    end

    // Fill 0x00..0x07.
    rst = 1'b0;
    rd  = 1'b0;
    wr  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(i);
      step();
      check("fill_empty", 32'(empty), 32'd0);
      check("fill_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
    end

    // Overflow write is dropped.
    data_in = 8'hAA;
    step();
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_dout", 32'(data_out), 32'h00);

    // Drain in order.
    wr = 1'b0;
    rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("drain_dout", 32'(data_out), 32'(i));
      check("drain_full", 32'(full), 32'd0);
      check("drain_empty", 32'(empty), (i == 7) ? 32'd1 : 32'd0);
    end
    step();
    check("underflow_dout", 32'(data_out), 32'h07);
    check("underflow_empty", 32'(empty), 32'd1);

    // rd & wr while empty: write only, data_out unchanged.
    wr      = 1'b1;
    data_in = 8'h30;
    step();
    check("simul_empty_dout", 32'(data_out), 32'h07);
    check("simul_empty_flag", 32'(empty), 32'd0);

    // Bring occupancy to 3: {30,31,32}.
    rd = 1'b0;
    for (int i = 1; i < 3; i++) begin
      data_in = 8'(8'h30 + i);
      step();
    end
    check("occ3_dout", 32'(data_out), 32'h07);

    // Ten simultaneous cycles across pointer wrap.
    rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'(8'h40 + i);
      step();
      check("simul_dout", 32'(data_out), (i < 3) ? 32'(8'h30 + i) : 32'(8'h40 + i - 3));
      check("simul_empty", 32'(empty), 32'd0);
      check("simul_full", 32'(full), 32'd0);
    end

    // Occupancy still 3: 0x47, 0x48, 0x49 remain.
    wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("tail_dout", 32'(data_out), 32'(8'h47 + i));
      check("tail_empty", 32'(empty), (i == 2) ? 32'd1 : 32'd0);
    end

    // Mid-operation reset after five writes.
    rd = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(8'h60 + i);
      step();
    end
    check("pre_rst_empty", 32'(empty), 32'd0);
    rst     = 1'b1;
    rd      = 1'b1;
    data_in = 8'hEE;
    step();
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_dout", 32'(data_out), 32'h00);

    rst     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b1;
    data_in = 8'h77;
    step();
    check("post_rst_wr_empty", 32'(empty), 32'd0);
    wr = 1'b0;
    rd = 1'b1;
    step();
    check("post_rst_dout", 32'(data_out), 32'h77);
    check("post_rst_empty", 32'(empty), 32'd1);

    rd = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
